ecall_console: RTL
==================

# ecall_console

Downstream consumer of the CPU's ecall print path. It takes one-cycle `print_flag` character strobes from `Top` and buffers them in a small FIFO. It serializes the characters onto an 8N1 UART line and reports back-pressure to the core. After `halt` it raises `drained` once every accepted character has left the wire, so the bench can end simulation without losing output.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; legal values are ≥2.
- `FIFO_DEPTH`, default 8: character buffer entries; must be a power of 2 and ≥2.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `print_flag`  in  1  one-cycle strobe: a character is valid on `print_data`.
- `print_data`  in  8  character to print (low byte of the core's argument register).
- `halt`  in  1  core has executed its terminating ecall; level or pulse.
- `busy`  out  1  FIFO full; the core must stall print ecalls while this is high.
- `tx`  out  1  UART serial output, idle high.
- `overflow`  out  1  sticky: at least one strobe was dropped because the FIFO was full.
- `drained`  out  1  halt seen, FIFO empty and transmitter idle.

## Operation
- Reset values:
  - `tx`=1, `busy`=0, `overflow`=0, `drained`=0.
  - FIFO empty (read/write pointers and count = 0), FSM in IDLE, `halt_seen`=0.
- Reset mid-frame aborts the frame immediately: `tx` goes to 1 asynchronously and buffered characters are discarded.
- FIFO:
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - The count is log2(FIFO_DEPTH)+1 bits.
  - `busy` = (count == FIFO_DEPTH).
- Push rule:
  - At an edge with `print_flag`=1 and `halt_seen`=0: if the registered count < FIFO_DEPTH, `print_data` is written. Otherwise the character is dropped and `overflow` is set.
  - There is no full-bypass: a pop in the same cycle does not make room for a push at full.
  - A simultaneous push and pop leaves the count unchanged.
- Strobes after `halt_seen`=1 are ignored and do not set `overflow`.
- `halt_seen` is set on any edge with `halt`=1 and cleared only by reset.
- TX FSM (IDLE, START, DATA, STOP), with bit counter 0..CLKS_PER_BIT-1 and data index 0..7:
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with index 0.
  - DATA: `tx`=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After index 7 completes, go to STOP. Bits go out LSB first.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- `tx` is driven from a register, so the output is glitch-free.
- `drained` = `halt_seen` & FIFO empty & state==IDLE, registered.

## Timing
- A push accepted at edge N is popped at edge N+1 if the FSM is in IDLE. `tx` falls after edge N+1, so start-bit latency is 1 cycle after the accepting edge.
- Frame length is 10·CLKS_PER_BIT cycles of START+DATA+STOP.
- Back-to-back frames have one IDLE cycle (`tx`=1) between them, so frame pitch = 10·CLKS_PER_BIT+1.
- `busy` rises the cycle after the push that fills the FIFO. It falls the cycle after the next pop.
- `drained` rises one cycle after the FSM enters IDLE with the FIFO empty and `halt_seen`=1. It then stays high until reset.
- `overflow` rises after the edge of the dropped strobe.

## Test plan
- Single character, CLKS_PER_BIT=4, push 0x41:
  - `tx` is low for 4 cycles starting 1 cycle after the push edge.
  - Data bits are then 1,0,0,0,0,0,1,0 for 4 cycles each, followed by 4 cycles high.
  - `overflow`=0 and `busy`=0 throughout.
- Burst of 10 strobes on consecutive edges (0x30..0x39), FIFO_DEPTH=8:
  - `busy` goes high after the 9th edge.
  - 0x39 is dropped and `overflow`=1.
  - Exactly 9 frames, 0x30..0x38 in order, appear at pitch 10·CLKS_PER_BIT+1.
- Halt drain: push 0x48, 0x69, then pulse `halt`:
  - `drained` stays 0 through both frames.
  - `drained` rises 1 cycle after the second stop bit ends.
- Print after halt: assert `halt`, then strobe 0x58. No frame appears on `tx`, `overflow` stays 0, and `drained` stays 1.
- Reset mid-frame: assert `rst` during DATA of 0x55 with 3 characters queued.
  - `tx`=1, `busy`=0 and `overflow`=0 immediately.
  - No further frames after `rst` deasserts.
- Wrap-around: push 20 characters paced at one per frame pitch. All 20 are received in order with `overflow`=0, which exercises pointer wrap more than twice.

Source files
------------

// File: rtl/ecall_console.sv
// ecall_console: consumes the core's ecall print strobes, buffers the
// characters in a small FIFO and serializes them onto an 8N1 UART line.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   FIFO_DEPTH    character buffer entries (power of 2, >= 2)
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   print_flag    one-cycle strobe, character valid on print_data
//   print_data    character to print
//   halt          core executed its terminating ecall (level or pulse)
//   busy          FIFO full, core must stall print ecalls
//   tx            UART serial output, idle high
//   overflow      sticky: a strobe was dropped because the FIFO was full
//   drained       halt seen, FIFO empty and transmitter idle
module ecall_console #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       print_flag,
    input  logic [7:0] print_data,
    input  logic       halt,
    output logic       busy,
    output logic       tx,
    output logic       overflow,
    output logic       drained
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned BIT_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } state_e;

    state_e             state_q, state_d;
    logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               overflow_q, overflow_d;
    logic               drained_q, drained_d;
    logic               halt_seen_q, halt_seen_d;

    logic [7:0]         mem_q [FIFO_DEPTH];

    logic               push;
    logic               drop;
    logic               pop;
    logic               bit_done;

    // FIFO bookkeeping and status flags
    always_comb begin
        push        = print_flag && !halt_seen_q && (count_q < CNT_W'(FIFO_DEPTH));
        drop        = print_flag && !halt_seen_q && !(count_q < CNT_W'(FIFO_DEPTH));
        pop         = (state_q == ST_IDLE) && (count_q != '0);

        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        count_d     = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        busy_d      = (count_d == CNT_W'(FIFO_DEPTH));
        overflow_d  = overflow_q | drop;
        halt_seen_d = halt_seen_q | halt;
        // Once set it holds: nothing can be queued after halt_seen.
        drained_d   = drained_q |
                      (halt_seen_q && (count_q == '0) && (state_q == ST_IDLE));
    end

    // UART transmit FSM; tx_d is the line level for the cycle after the edge
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        bit_done  = (bit_cnt_q == BIT_W'(CLKS_PER_BIT - 1));

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d   = mem_q[rd_ptr_q];
                    bit_cnt_d = '0;
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    bit_cnt_d = '0;
                    idx_d     = 3'd0;
                    state_d   = ST_DATA;
                    tx_d      = shift_q[0];
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    bit_cnt_d = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        // next bit is the one about to land in shift[0]
                        tx_d  = shift_q[1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    bit_cnt_d = '0;
                    state_d   = ST_IDLE;
                    tx_d      = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            drained_q   <= 1'b0;
            halt_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            drained_q   <= drained_d;
            halt_seen_q <= halt_seen_d;
        end
    end

    // Character storage; contents are don't-care once the pointers reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= print_data;
        end
    end

    assign busy     = busy_q;
    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign drained  = drained_q;

endmodule
